// File: rtl/row_sync_arbiter.sv
// Row responder: round-robin URAM arbitration across the row's cores, shared URAM
// port mux, and the all-locked barrier handshake with the host.
module row_sync_arbiter #(
  parameter int NUM_CORES = 8,
  parameter int IDX_W     = $clog2(NUM_CORES)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CORES-1:0]     i_core_req,
  input  logic [NUM_CORES-1:0]     i_core_locked,
  output logic [NUM_CORES-1:0]     o_core_grant,
  output logic [NUM_CORES-1:0]     o_uram_emptied,
  input  logic [NUM_CORES-1:0]     i_core_uram_en,
  input  logic [NUM_CORES*12-1:0]  i_core_uram_addr,
  input  logic [NUM_CORES*32-1:0]  i_core_uram_wr_data,
  input  logic [NUM_CORES-1:0]     i_core_uram_wr_en,
  output logic                     o_uram_en,
  output logic [11:0]              o_uram_addr,
  output logic [31:0]              o_uram_wr_data,
  output logic                     o_uram_wr_en,
  output logic                     o_row_full,
  input  logic                     i_host_emptied
);

  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_HOLDOFF} arb_state_t;
  typedef enum logic {BAR_RUN, BAR_FULL} bar_state_t;

  arb_state_t           arb_state;
  bar_state_t           bar_state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     grant_idx;
  logic [NUM_CORES-1:0] eligible;
  logic [IDX_W-1:0]     pick_idx;
  logic                 grant_active;

  assign eligible     = i_core_req & ~i_core_locked;
  assign grant_active = (arb_state == ARB_GRANT);

  // Scan downward so the lowest rotated offset from rr_ptr wins.
  always_comb begin
    int idx;
    idx      = 0;
    pick_idx = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (eligible[IDX_W'(idx)]) pick_idx = IDX_W'(idx);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      arb_state    <= ARB_IDLE;
      o_core_grant <= '0;
      grant_idx    <= '0;
      rr_ptr       <= '0;
    end else begin
      case (arb_state)
        ARB_IDLE: begin
          if (|eligible) begin
            o_core_grant <= NUM_CORES'(1) << pick_idx;
            grant_idx    <= pick_idx;
            arb_state    <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          // Lock does not revoke an active grant; only the request drop ends it.
          if (!i_core_req[grant_idx]) begin
            o_core_grant <= '0;
            rr_ptr       <= (grant_idx == IDX_W'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
            arb_state    <= ARB_HOLDOFF;
          end
        end
        ARB_HOLDOFF: arb_state <= ARB_IDLE;
        default:     arb_state <= ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bar_state      <= BAR_RUN;
      o_row_full     <= 1'b0;
      o_uram_emptied <= '0;
    end else begin
      o_uram_emptied <= o_uram_emptied & i_core_locked;
      case (bar_state)
        BAR_RUN: begin
          if ((&i_core_locked) && arb_state == ARB_IDLE) begin
            o_row_full <= 1'b1;
            bar_state  <= BAR_FULL;
          end
        end
        BAR_FULL: begin
          // A lock drop outranks a simultaneous host acknowledge.
          if (!(&i_core_locked)) begin
            o_row_full <= 1'b0;
            bar_state  <= BAR_RUN;
          end else if (i_host_emptied) begin
            o_row_full     <= 1'b0;
            o_uram_emptied <= '1;
            bar_state      <= BAR_RUN;
          end
        end
        default: bar_state <= BAR_RUN;
      endcase
    end
  end

  always_comb begin
    o_uram_en      = 1'b0;
    o_uram_addr    = '0;
    o_uram_wr_data = '0;
    o_uram_wr_en   = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (grant_active && grant_idx == IDX_W'(i)) begin
        o_uram_en      = i_core_uram_en[i];
        o_uram_addr    = i_core_uram_addr[i*12 +: 12];
        o_uram_wr_data = i_core_uram_wr_data[i*32 +: 32];
        o_uram_wr_en   = i_core_uram_wr_en[i];
      end
    end
  end

endmodule
